// File: rtl/mult_ram_pkg.sv
// Shared definitions for the multiply-to-RAM datapath stage:
// FSM state encoding and default operand/address widths.
package mult_ram_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-add multiplier core: go loads the operands,
// each step consumes one multiplier bit; last flags the final step.
module shift_add_mult
  import mult_ram_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (go) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_ram_stage.sv
// Operand capture, multiply sequencing and product storage: A*B is written
// into a small result RAM at the address latched with start.
module mult_ram_stage
  import mult_ram_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    opnd,
  input  logic                ld_a,
  input  logic                ld_b,
  input  logic                start,
  input  logic [ADDR_W-1:0]   dest_adr,
  input  logic [ADDR_W-1:0]   rd_adr,
  output logic [2*WIDTH-1:0]  rd_data,
  output logic [2*WIDTH-1:0]  product,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              state_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [ADDR_W-1:0]   dest_q;
  logic [2*WIDTH-1:0]  product_q, rd_data_q;
  logic                busy_q, done_q;
  logic [2*WIDTH-1:0]  mem_q [DEPTH];

  logic               core_go, core_step, core_last;
  logic [2*WIDTH-1:0] core_acc;

  // The core samples a_q/b_q at the start edge, so a load on that same edge
  // only affects the next operation.
  assign core_go   = (state_q == IDLE) && start;
  assign core_step = (state_q == MUL);

  shift_add_mult #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .go    (core_go),
    .step  (core_step),
    .a     (a_q),
    .b     (b_q),
    .acc   (core_acc),
    .last  (core_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      dest_q    <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_a) a_q <= opnd;
          if (ld_b) b_q <= opnd;
          if (start) begin
            dest_q  <= dest_adr;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          if (core_last) state_q <= WRITE;
        end
        WRITE: begin
          product_q <= core_acc;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read samples the pre-write contents, giving read-before-write on collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (state_q == WRITE) mem_q[dest_q] <= core_acc;
      rd_data_q <= mem_q[rd_adr];
    end
  end

  assign rd_data = rd_data_q;
  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = start && busy_q;

endmodule

// File: tb/tb_mult_ram_stage.sv
// Directed and randomized checks of mult_ram_stage against an arithmetic
// model of the result RAM and operand registers.
module tb_mult_ram_stage;

  localparam int W  = 4;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  opnd;
  logic          ld_a, ld_b, start;
  logic [AW-1:0] dest_adr, rd_adr;
  logic [2*W-1:0] rd_data, product;
  logic          busy, done, err;

  int compared = 0;
  int mismatched = 0;

  logic [2*W-1:0] ram_m [N];
  logic [W-1:0]   a_m, b_m;

  mult_ram_stage #(.WIDTH(W), .ADDR_W(AW), .DEPTH(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .opnd     (opnd),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .start    (start),
    .dest_adr (dest_adr),
    .rd_adr   (rd_adr),
    .rd_data  (rd_data),
    .product  (product),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    opnd = a; ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0; opnd = b; ld_b = 1'b1;
    @(negedge clk);
    ld_b = 1'b0;
    a_m = a; b_m = b;
  endtask

  task automatic rd_chk(input logic [AW-1:0] adr);
    rd_adr = adr;
    @(negedge clk);
    chk($sformatf("rd_data[%0d]", adr), int'(rd_data), int'(ram_m[adr]));
  endtask

  // mode: 0 plain, 1 second start + ld_a in MUL cycle 2, 2 read collision,
  // 3 reset in MUL cycle 2, 4 load nv into A and B on the start edge.
  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle.
  task automatic run_op(input logic [AW-1:0] dest, input int mode, input logic [W-1:0] nv);
    logic [2*W-1:0] exp_p, old;
    int n;
    exp_p = (2*W)'(a_m) * (2*W)'(b_m);
    old   = ram_m[dest];
    start = 1'b1; dest_adr = dest;
    if (mode == 2) rd_adr = dest;
    if (mode == 4) begin ld_a = 1'b1; ld_b = 1'b1; opnd = nv; end
    @(negedge clk);
    start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
    if (mode == 4) begin a_m = nv; b_m = nv; end
    chk("busy_after_start", int'(busy), 1);
    n = 1;
    while (n <= 20) begin
      if (done === 1'b1) break;
      if (mode == 1 && n == 2) begin
        start = 1'b1; dest_adr = dest + 3'd1; ld_a = 1'b1; opnd = ~a_m;
        #1 chk("err_pulse", int'(err), 1);
      end
      if (mode == 1 && n == 3) begin
        start = 1'b0; ld_a = 1'b0;
        #1 chk("err_clear", int'(err), 0);
      end
      if (mode == 3 && n == 2) begin
        reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) ram_m[i] = '0;
        a_m = '0; b_m = '0;
        chk("abort_product", int'(product), 0);
        $display("op dest=%0d aborted by reset", dest);
        return;
      end
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, W + 2);
    chk("product", int'(product), int'(exp_p));
    chk("busy_in_done", int'(busy), 1);
    ram_m[dest] = exp_p;
    if (mode == 2) chk("collide_old", int'(rd_data), int'(old));
    @(negedge clk);
    chk("done_pulse_end", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    if (mode == 2) chk("collide_new", int'(rd_data), int'(exp_p));
    $display("op dest=%0d mode=%0d product=%0d expected=%0d", dest, mode, product, exp_p);
  endtask

  initial begin
    reset = 1'b1; opnd = '0; ld_a = 1'b0; ld_b = 1'b0; start = 1'b0;
    dest_adr = '0; rd_adr = '0;
    for (int i = 0; i < N; i++) ram_m[i] = '0;
    a_m = '0; b_m = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_product", int'(product), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    reset = 1'b0;
    @(negedge clk);

    load_ab(4'd7, 4'd5);  run_op(3'd3, 0, 4'd0); rd_chk(3'd3);
    load_ab(4'd15, 4'd15); run_op(3'd7, 0, 4'd0); rd_chk(3'd7);
    load_ab(4'd0, 4'd9);  run_op(3'd0, 0, 4'd0);
    load_ab(4'd9, 4'd0);  run_op(3'd2, 0, 4'd0);

    // Second start while busy: ignored, and the ld_a with it too.
    load_ab(4'd6, 4'd2);  run_op(3'd6, 1, 4'd0);
    run_op(3'd2, 0, 4'd0);
    rd_chk(3'd6); rd_chk(3'd7);

    load_ab(4'd6, 4'd6);  run_op(3'd1, 3, 4'd0);
    rd_chk(3'd1); rd_chk(3'd3);
    load_ab(4'd3, 4'd4);  run_op(3'd1, 0, 4'd0); rd_chk(3'd1);

    load_ab(4'd11, 4'd3); run_op(3'd6, 2, 4'd0);

    // Back-to-back: second start in the first IDLE cycle after DONE.
    load_ab(4'd2, 4'd3);
    run_op(3'd4, 0, 4'd0);
    run_op(3'd3, 4, 4'd5);
    run_op(3'd5, 0, 4'd0);

    for (int k = 0; k < 6; k++) begin
      load_ab(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      run_op(AW'($urandom_range(0, 7)), 0, 4'd0);
    end

    for (int i = 0; i < N; i++) rd_chk(AW'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_ram_stage.md
Name: mult_ram_stage

Overview:
- Datapath stage directly downstream of the lab control unit.
- Captures two operands from the register-file read bus under load strobes, then runs an iterative shift-add multiply.
- Writes the 2*WIDTH-bit product into a small result RAM at a destination address.
- Exposes a synchronous read port so the product can be displayed or read back afterwards.

Parameters:
- WIDTH, 4: operand width in bits; product is 2*WIDTH bits.
- ADDR_W, 3: result RAM address width.
- DEPTH, 8: result RAM entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opnd  in  WIDTH  operand bus from register file.
- ld_a  in  1  load opnd into A register.
- ld_b  in  1  load opnd into B register.
- start  in  1  begin multiply A*B.
- dest_adr  in  ADDR_W  RAM write address; sampled on start.
- rd_adr  in  ADDR_W  RAM read address.
- rd_data  out  2*WIDTH  RAM read data, registered.
- product  out  2*WIDTH  last completed product, registered.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset, asynchronous, active-high:
  - state=IDLE; A=B=0; product=0; rd_data=0; busy=done=err=0.
  - All RAM entries cleared to 0.
  - Count, accumulator and latched dest cleared.
- Operand loads, IDLE only:
  - ld_a: A<=opnd. ld_b: B<=opnd. Both high: both load the same opnd.
  - ld_a/ld_b ignored while busy.
- FSM states: IDLE, MUL, WRITE, DONE.
  - IDLE: start=1 -> MUL. Same edge: latch dest_adr, accumulator<=0, multiplicand<=A zero-extended to 2*WIDTH, multiplier<=B, count<=0.
  - IDLE: if ld_x and start are high together, the load still updates A/B, but the multiply uses the pre-edge A/B values.
  - MUL: each cycle, if multiplier[0], accumulator += multiplicand; then multiplicand<<=1, multiplier>>=1, count++. After WIDTH cycles (count==WIDTH-1 on the edge) -> WRITE.
  - WRITE: ram[dest]<=accumulator and product<=accumulator at the end of this cycle -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- Latency: start sampled at edge k; done high during cycle k+WIDTH+1, i.e. WIDTH+2 cycles including the start cycle. busy high from edge k until the DONE->IDLE edge.
- Arithmetic: unsigned, 2*WIDTH accumulator; no overflow is possible.
- start while busy: ignored; err=1 for that cycle; the operation in flight is unaffected.
- RAM read:
  - rd_data<=ram[rd_adr] every cycle; 1-cycle latency; independent of FSM state.
  - Read and write to the same address in the same cycle returns old data; new data appears on the following read.
- Reset mid-operation: abort immediately to IDLE. No RAM write and no done. Entries written earlier are also cleared by the reset.
- Back-to-back: start may be asserted in the first IDLE cycle after DONE and is accepted.

Decomposition:
- Package mult_ram_pkg holds:
  - state encoding (IDLE=0, MUL=1, WRITE=2, DONE=3, 2 bits);
  - default WIDTH/ADDR_W constants.
- Sub-module shift_add_mult holds the iterative multiplier core:
  - inputs: go, a, b;
  - outputs: acc, last;
  - the top module keeps the FSM, operand registers and RAM.

Test Plan:
- A=7, B=5, dest 3 -> done pulses at start edge+5 (WIDTH=4), ram[3] and product =35, rd_adr=3 gives rd_data=35 next cycle.
- A=15, B=15, dest 7 -> product 225 (0xE1); A=0, B=9, dest 0 -> 0; A=9, B=0 -> 0; other entries unchanged.
- start pulsed twice, the second in MUL cycle 2 -> err pulses once, a single done, only the first result written; ld_a during busy leaves A unchanged.
- Reset asserted in MUL cycle 2 of 6*6 to dest 1 -> busy=0 immediately, no done, ram[1]=0; a following 3*4 completes to 12.
- rd_adr=dest held during WRITE of 11*3 -> rd_data old value (0) that cycle, 33 the next.
- Two back-to-back ops (2*3 to dest 4, start in the cycle after DONE; 5*5 to dest 5) -> ram[4]=6, ram[5]=25, both done pulses present.
